lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter DLY_CYCLES, default 18'h3FFFE: inter-transfer settle delay, in iCLK cycles.
REQ-002 iCLK  input  1  clock; one clock domain only, all state updates on rising edge.
REQ-003 iRST  input  1  reset; synchronous, active-high.
REQ-004 iUPDATE  input  1  single-cycle request to redraw the result line.
REQ-005 iA  input  4  first operand, BCD digit.
REQ-006 iB  input  4  second operand, BCD digit.
REQ-007 iOP  input  2  operation code: 0 add, 1 sub, 2 mul, 3 div.
REQ-008 iRES_HI, iRES_LO  input  4 each  result tens and units, BCD.
REQ-009 oDATA  output  8  byte presented to the LCD driver.
REQ-010 oRS  output  1  0 = command byte, 1 = character byte.
REQ-011 oSTART  output  1  transfer request to the LCD driver.
REQ-012 iDONE  input  1  driver completion pulse.
REQ-013 oBUSY  output  1  high while any sequence is in progress.

Function
REQ-014 State machine states: INIT_LOAD, XFER_START, XFER_WAIT, XFER_DELAY, IDLE, UPD_LOAD.
REQ-015 Init table, fixed at 5 entries, all commands (oRS=0), in order: 0x38, 0x0C, 0x01, 0x06, 0x80.
- The sequencer issues the init table automatically after reset.
- It then enters IDLE.
REQ-016 Update table, 7 entries: command 0x80, then characters A, OP, B, '=', RES_HI, RES_LO.
REQ-017 Character mapping:
- Digit d in 0..9 maps to 0x30+d.
- Digit greater than 9 maps to '?' (0x3F).
- OP maps to 0x2B, 0x2D, 0x2A, 0x2F for codes 0 to 3.
- RES_HI == 0 maps to space (0x20).
REQ-018 Transfer handshake per entry:
- XFER_START drives oDATA/oRS and asserts oSTART.
- oSTART holds until the cycle iDONE is sampled high.
- oSTART deasserts on the next cycle.
- The FSM then enters XFER_DELAY.
REQ-019 XFER_DELAY counts 0 to DLY_CYCLES-1, then advances the entry index or ends the sequence.
- Counter width is 18 bits.
- Counter clears on every entry to XFER_DELAY.
REQ-020 oDATA/oRS stay stable from oSTART assertion until iDONE is sampled.
REQ-021 iA, iB, iOP, iRES_* are snapshotted in UPD_LOAD.
- Later input changes do not affect a sequence in progress.
REQ-022 iUPDATE in IDLE: UPD_LOAD is entered on the next cycle, and oSTART asserts one cycle after that.
REQ-023 iUPDATE while busy (init or update) sets a pending flag.
- The pending sequence starts immediately after the current one ends.
- Multiple requests collapse into one.
REQ-024 iDONE arriving outside XFER_WAIT is ignored.
REQ-025 oBUSY is low only in IDLE with no pending request.

Reset
REQ-026 iRST high forces, on the next edge:
- oSTART=0, oDATA=0x00, oRS=0, oBUSY=1;
- pending flag cleared, delay counter cleared, index 0;
- state INIT_LOAD.
REQ-027 Reset mid-transfer aborts the transfer immediately; the full init table is replayed after release.

Configuration
REQ-028 Macro LCD_SEQ_CLEAR_EN.
- Defined: the update table is prefixed with command 0x01 (8 entries total).
- Undefined: the update table is exactly REQ-016 and overwrites line 1 in place.

Structure
REQ-029 Shared package lcd_seq_pkg holds:
- the state encoding;
- the init/update table lengths;
- the command constants 0x38, 0x0C, 0x01, 0x06, 0x80;
- the ASCII constants for the operators, '=', space and '?'.
REQ-030 One sub-module, lcd_char_map: combinational BCD/op to ASCII mapping per REQ-017.

Verification
REQ-031 Release reset, DLY_CYCLES=4, iDONE driven 3 cycles after each oSTART -> exactly 5 transfers 0x38, 0x0C, 0x01, 0x06, 0x80 with oRS=0, then oBUSY=0.
REQ-032 iA=3, iB=4, iOP=0, iRES_HI=0, iRES_LO=7, pulse iUPDATE -> bytes 0x80 (oRS=0), then 0x33, 0x2B, 0x34, 0x3D, 0x20, 0x37 (oRS=1).
REQ-033 iOP=2, iRES_HI=1, iRES_LO=2, iA=12 -> A character is 0x3F, OP character is 0x2A, result bytes are 0x31, 0x32.
REQ-034 Three iUPDATE pulses during the init sequence -> exactly one update sequence follows init; iOP changed mid-update does not change the emitted OP byte.
REQ-035 iRST asserted while in XFER_WAIT on update entry 3 -> oSTART=0 on the next edge; after release the first byte is 0x38.
REQ-036 With LCD_SEQ_CLEAR_EN defined, pulse iUPDATE -> first update byte is 0x01 (oRS=0), 8 transfers total.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// rtl/lcd_seq_pkg.sv - state encoding, table lengths and byte constants for the LCD sequencer
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        INIT_LOAD,
        XFER_START,
        XFER_WAIT,
        XFER_DELAY,
        IDLE,
        UPD_LOAD
    } state_e;

    localparam logic [3:0] INIT_LEN = 4'd5;
`ifdef LCD_SEQ_CLEAR_EN
    localparam logic [3:0] UPD_LEN  = 4'd8;
    localparam logic [2:0] UPD_HDR  = 3'd2;
`else
    localparam logic [3:0] UPD_LEN  = 4'd7;
    localparam logic [2:0] UPD_HDR  = 3'd1;
`endif

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_HOME     = 8'h80;

    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_MUL   = 8'h2A;
    localparam logic [7:0] CH_DIV   = 8'h2F;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
        return (d <= 4'd9) ? (CH_ZERO + {4'h0, d}) : CH_QMARK;
    endfunction

endpackage

// File: rtl/lcd_char_map.sv
// rtl/lcd_char_map.sv - combinational BCD digit / operator code to ASCII mapping
module lcd_char_map
    import lcd_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    input  logic [3:0] res_hi,
    input  logic [3:0] res_lo,
    output logic [7:0] a_chr,
    output logic [7:0] op_chr,
    output logic [7:0] b_chr,
    output logic [7:0] hi_chr,
    output logic [7:0] lo_chr
);

    always_comb begin
        a_chr  = bcd_to_ascii(a);
        b_chr  = bcd_to_ascii(b);
        lo_chr = bcd_to_ascii(res_lo);
        // a leading zero in the tens place is blanked
        hi_chr = (res_hi == 4'd0) ? CH_SPACE : bcd_to_ascii(res_hi);
        case (op)
            2'd0:    op_chr = CH_PLUS;
            2'd1:    op_chr = CH_MINUS;
            2'd2:    op_chr = CH_MUL;
            default: op_chr = CH_DIV;
        endcase
    end

endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - LCD init/update byte sequencer; LCD_SEQ_CLEAR_EN prefixes updates with a clear
module lcd_sequencer
    import lcd_seq_pkg::*;
#(
    parameter logic [17:0] DLY_CYCLES = 18'h3FFFE
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iUPDATE,
    input  logic [3:0] iA,
    input  logic [3:0] iB,
    input  logic [1:0] iOP,
    input  logic [3:0] iRES_HI,
    input  logic [3:0] iRES_LO,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oSTART,
    input  logic       iDONE,
    output logic       oBUSY
);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        mode_q, mode_d;
    logic [17:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        start_q, start_d;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        busy_q, busy_d;
    logic [3:0]  a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [1:0]  op_q, op_d;

    logic [7:0]  a_chr, op_chr, b_chr, hi_chr, lo_chr;
    logic [2:0]  ld_idx;
    logic        ld_mode;
    logic [7:0]  ent_data;
    logic        ent_rs;
    logic        launch;
    logic        dly_done;
    logic        more;

    lcd_char_map u_char_map (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .res_hi (hi_q),
        .res_lo (lo_q),
        .a_chr  (a_chr),
        .op_chr (op_chr),
        .b_chr  (b_chr),
        .hi_chr (hi_chr),
        .lo_chr (lo_chr)
    );

    // Entry that would be launched this cycle: first of a sequence, or the one after idx_q.
    always_comb begin
        ld_mode = mode_q;
        ld_idx  = idx_q + 3'd1;
        if (state_q == INIT_LOAD) begin
            ld_mode = 1'b0;
            ld_idx  = 3'd0;
        end else if (state_q == UPD_LOAD) begin
            ld_mode = 1'b1;
            ld_idx  = 3'd0;
        end
    end

    always_comb begin
        ent_rs   = 1'b0;
        ent_data = CMD_HOME;
        if (!ld_mode) begin
            case (ld_idx)
                3'd0:    ent_data = CMD_FUNC_SET;
                3'd1:    ent_data = CMD_DISP_ON;
                3'd2:    ent_data = CMD_CLEAR;
                3'd3:    ent_data = CMD_ENTRY;
                default: ent_data = CMD_HOME;
            endcase
        end else if (ld_idx < UPD_HDR) begin
`ifdef LCD_SEQ_CLEAR_EN
            ent_data = (ld_idx == 3'd0) ? CMD_CLEAR : CMD_HOME;
`else
            ent_data = CMD_HOME;
`endif
        end else begin
            ent_rs = 1'b1;
            case (ld_idx - UPD_HDR)
                3'd0:    ent_data = a_chr;
                3'd1:    ent_data = op_chr;
                3'd2:    ent_data = b_chr;
                3'd3:    ent_data = CH_EQ;
                3'd4:    ent_data = hi_chr;
                default: ent_data = lo_chr;
            endcase
        end
    end

    assign dly_done = (cnt_q == DLY_CYCLES - 18'd1) || (DLY_CYCLES == 18'd0);
    assign more     = ({1'b0, idx_q} + 4'd1) < (mode_q ? UPD_LEN : INIT_LEN);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        start_d = start_q;
        data_d  = data_q;
        rs_d    = rs_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        launch  = 1'b0;
        if (iUPDATE && state_q != IDLE) pend_d = 1'b1;
        case (state_q)
            INIT_LOAD: launch = 1'b1;
            UPD_LOAD: begin
                launch = 1'b1;
                a_d    = iA;
                b_d    = iB;
                op_d   = iOP;
                hi_d   = iRES_HI;
                lo_d   = iRES_LO;
            end
            XFER_START: state_d = XFER_WAIT;
            XFER_WAIT: begin
                if (iDONE) begin
                    start_d = 1'b0;
                    cnt_d   = 18'd0;
                    state_d = XFER_DELAY;
                end
            end
            XFER_DELAY: begin
                cnt_d = cnt_q + 18'd1;
                if (dly_done) begin
                    if (more) begin
                        launch = 1'b1;
                    end else if (pend_q || iUPDATE) begin
                        state_d = UPD_LOAD;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            IDLE: if (iUPDATE) state_d = UPD_LOAD;
            default: state_d = INIT_LOAD;
        endcase
        if (launch) begin
            state_d = XFER_START;
            start_d = 1'b1;
            data_d  = ent_data;
            rs_d    = ent_rs;
            idx_d   = ld_idx;
            mode_d  = ld_mode;
        end
        busy_d = (state_d != IDLE) || pend_d;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= INIT_LOAD;
            idx_q   <= 3'd0;
            mode_q  <= 1'b0;
            cnt_q   <= 18'd0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            rs_q    <= 1'b0;
            busy_q  <= 1'b1;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            op_q    <= 2'd0;
            hi_q    <= 4'd0;
            lo_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            busy_q  <= busy_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign oDATA  = data_q;
    assign oRS    = rs_q;
    assign oSTART = start_q;
    assign oBUSY  = busy_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - self-checking bench for lcd_sequencer (honours LCD_SEQ_CLEAR_EN)
module tb_lcd_sequencer;

    localparam logic [17:0] DLY = 18'd4;

    logic       clk = 1'b0;
    logic       rst, upd, done_auto, done_stray, done;
    logic [3:0] a, b, hi, lo;
    logic [1:0] op;
    logic [7:0] oDATA;
    logic       oRS, oSTART, oBUSY;

    assign done = done_auto | done_stray;
    always #5 clk = ~clk;

    lcd_sequencer #(.DLY_CYCLES(DLY)) dut (
        .iCLK(clk), .iRST(rst), .iUPDATE(upd), .iA(a), .iB(b), .iOP(op),
        .iRES_HI(hi), .iRES_LO(lo), .oDATA(oDATA), .oRS(oRS), .oSTART(oSTART),
        .iDONE(done), .oBUSY(oBUSY)
    );

    int pass_cnt = 0;
    int tot_cnt  = 0;
    int stab_err = 0;
    logic [8:0] cap[$];
    logic [8:0] exp_q[$];
    logic [8:0] held;
    logic       prev_start = 1'b0;

    typedef struct packed {
        logic [3:0]  a;
        logic [3:0]  b;
        logic [1:0]  op;
        logic [3:0]  hi;
        logic [3:0]  lo;
        logic [47:0] chars;
    } vec_t;
    vec_t tbl[4];

    // Transfer monitor: one record per oSTART rise, and the byte must hold while oSTART is high.
    initial forever begin
        @(negedge clk);
        if (oSTART && !prev_start) begin
            cap.push_back({oRS, oDATA});
            held = {oRS, oDATA};
        end else if (oSTART && ({oRS, oDATA} !== held)) begin
            stab_err++;
        end
        prev_start = oSTART;
    end

    // LCD driver model: completion pulse sampled 3 cycles after oSTART rises.
    initial begin
        done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (oSTART) begin
                repeat (2) @(negedge clk);
                done_auto = 1'b1;
                @(negedge clk);
                done_auto = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tot_cnt++;
        if (act !== req) $display("FAIL %s: got %0h expected %0h", nm, act, req);
        else pass_cnt++;
    endtask

    function automatic logic [7:0] digit_chr(input logic [3:0] d);
        string digits = "0123456789";
        if (d > 4'd9) return 8'h3F;
        return digits[d];
    endfunction

    function automatic logic [7:0] op_chr(input logic [1:0] o);
        string ops = "+-*/";
        return ops[o];
    endfunction

    task automatic push_hdr();
`ifdef LCD_SEQ_CLEAR_EN
        exp_q.push_back(9'h001);
`endif
        exp_q.push_back(9'h080);
    endtask

    task automatic push_model(input logic [3:0] ma, input logic [3:0] mb, input logic [1:0] mo,
                              input logic [3:0] mh, input logic [3:0] ml);
        push_hdr();
        exp_q.push_back({1'b1, digit_chr(ma)});
        exp_q.push_back({1'b1, op_chr(mo)});
        exp_q.push_back({1'b1, digit_chr(mb)});
        exp_q.push_back({1'b1, "="});
        exp_q.push_back({1'b1, (mh == 4'd0) ? " " : digit_chr(mh)});
        exp_q.push_back({1'b1, digit_chr(ml)});
    endtask

    task automatic push_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h080);
    endtask

    task automatic check_seq(input string nm);
        chk({nm, "_count"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            chk($sformatf("%s_byte%0d", nm, i), {23'd0, cap[i]}, {23'd0, exp_q[i]});
    endtask

    task automatic pulse_update();
        @(negedge clk);
        upd = 1'b1;
        @(negedge clk);
        upd = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (oBUSY && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_idle_timeout"}, {31'd0, oBUSY}, 32'd0);
    endtask

    task automatic wait_cap(input int n, input string nm);
        int k = 0;
        while (cap.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_cap_timeout"}, (cap.size() >= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic set_in(input logic [3:0] ia, input logic [3:0] ib, input logic [1:0] io,
                          input logic [3:0] ih, input logic [3:0] il);
        a = ia; b = ib; op = io; hi = ih; lo = il;
    endtask

    initial begin
        rst = 1'b1; upd = 1'b0; done_stray = 1'b0;
        set_in(4'd0, 4'd0, 2'd0, 4'd0, 4'd0);
        tbl[0] = '{4'd3,  4'd4,  2'd0, 4'd0,  4'd7, 48'h33_2B_34_3D_20_37};
        tbl[1] = '{4'd12, 4'd5,  2'd2, 4'd1,  4'd2, 48'h3F_2A_35_3D_31_32};
        tbl[2] = '{4'd9,  4'd0,  2'd1, 4'd9,  4'd9, 48'h39_2D_30_3D_39_39};
        tbl[3] = '{4'd0,  4'd15, 2'd3, 4'd10, 4'd0, 48'h30_2F_3F_3D_3F_30};

        // Reset state and init table
        repeat (2) @(negedge clk);
        chk("rst_start", {31'd0, oSTART}, 32'd0);
        chk("rst_data",  {24'd0, oDATA},  32'd0);
        chk("rst_rs",    {31'd0, oRS},    32'd0);
        chk("rst_busy",  {31'd0, oBUSY},  32'd1);
        cap.delete();
        rst = 1'b0;
        wait_idle("init");
        exp_q.delete(); push_init(); check_seq("init");

        // Update issue latency from IDLE
        set_in(4'd1, 4'd2, 2'd1, 4'd0, 4'd1);
        cap.delete();
        @(negedge clk); upd = 1'b1;
        @(negedge clk); upd = 1'b0;
        chk("lat_load_start", {31'd0, oSTART}, 32'd0);
        @(negedge clk);
        chk("lat_first_start", {31'd0, oSTART}, 32'd1);
`ifdef LCD_SEQ_CLEAR_EN
        chk("lat_first_byte", {23'd0, oRS, oDATA}, 32'h001);
`else
        chk("lat_first_byte", {23'd0, oRS, oDATA}, 32'h080);
`endif
        wait_idle("lat");
        exp_q.delete(); push_model(4'd1, 4'd2, 2'd1, 4'd0, 4'd1); check_seq("lat");

        // Table-driven vectors with hand-computed character bytes
        for (int v = 0; v < 4; v++) begin
            set_in(tbl[v].a, tbl[v].b, tbl[v].op, tbl[v].hi, tbl[v].lo);
            cap.delete();
            pulse_update();
            wait_idle($sformatf("tbl%0d", v));
            exp_q.delete();
            push_hdr();
            for (int k = 0; k < 6; k++) exp_q.push_back({1'b1, tbl[v].chars[47 - 8*k -: 8]});
            check_seq($sformatf("tbl%0d", v));
        end

        // Randomized operands against the reference model
        for (int r = 0; r < 6; r++) begin
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            cap.delete();
            pulse_update();
            exp_q.delete(); push_model(a, b, op, hi, lo);
            wait_idle($sformatf("rnd%0d", r));
            check_seq($sformatf("rnd%0d", r));
        end

        // Requests during an update collapse into one follow-on sequence
        set_in(4'd8, 4'd2, 2'd3, 4'd0, 4'd4);
        cap.delete();
        pulse_update();
        wait_cap(2, "pend");
        pulse_update();
        repeat (5) @(negedge clk);
        pulse_update();
        wait_idle("pend");
        exp_q.delete(); push_model(4'd8, 4'd2, 2'd3, 4'd0, 4'd4); push_model(4'd8, 4'd2, 2'd3, 4'd0, 4'd4);
        check_seq("pend");

        // Three requests during init -> exactly one update; inputs changed mid-update are ignored
        set_in(4'd5, 4'd6, 2'd1, 4'd2, 4'd3);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        cap.delete();
        repeat (2) @(negedge clk);
        pulse_update();
        repeat (8) @(negedge clk);
        pulse_update();
        repeat (15) @(negedge clk);
        pulse_update();
        wait_cap(6, "init_upd");
        set_in(4'd7, 4'd6, 2'd3, 4'd2, 4'd3);
        wait_idle("init_upd");
        exp_q.delete(); push_init(); push_model(4'd5, 4'd6, 2'd1, 4'd2, 4'd3);
        check_seq("init_upd");
        repeat (60) @(negedge clk);
        chk("init_upd_no_extra", cap.size(), exp_q.size());
        chk("init_upd_busy", {31'd0, oBUSY}, 32'd0);

        // Reset while waiting on update entry 3
        cap.delete();
        pulse_update();
        wait_cap(4, "rst_mid");
        @(negedge clk);
        chk("rst_mid_in_wait", {31'd0, oSTART}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_start", {31'd0, oSTART}, 32'd0);
        chk("rst_mid_data",  {24'd0, oDATA},  32'd0);
        chk("rst_mid_busy",  {31'd0, oBUSY},  32'd1);
        rst = 1'b0;
        cap.delete();
        wait_cap(1, "rst_replay");
        chk("rst_replay_first", (cap.size() > 0) ? {23'd0, cap[0]} : 32'hFFFF, 32'h038);
        wait_idle("rst_replay");
        exp_q.delete(); push_init(); check_seq("rst_replay");

        // Stray completion pulse in IDLE must not start anything
        cap.delete();
        @(negedge clk); done_stray = 1'b1;
        @(negedge clk); done_stray = 1'b0;
        repeat (10) @(negedge clk);
        chk("stray_no_xfer", cap.size(), 32'd0);
        chk("stray_busy", {31'd0, oBUSY}, 32'd0);

        chk("data_stable", stab_err, 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
